regfile_wb_arbiter: RTL and testbench

//   Shares the single write port of the 32x32 register file between two writeback

---
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback sources onto the single regfile write port
// and tracks pending writes in a per-register busy scoreboard.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   a_valid/a_ready/a_rd/a_data  source A (ALU/branch) writeback handshake
//   b_valid/b_ready/b_rd/b_data  source B (load/mul-div) writeback handshake
//   rsv_valid/rsv_rd           issue-stage destination reservation
//   busy                       scoreboard, bit i set while xi has a write pending
//   RegWrite/WriteRegister/WriteData  registered regfile write port
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_rd,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_valid,
    input  logic [4:0]        rsv_rd,
    output logic [31:0]       busy,
    output logic              RegWrite,
    output logic [4:0]        WriteRegister,
    output logic [DATA_W-1:0] WriteData
);
    logic              last_b;
    logic              grant_a;
    logic              grant_b;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       clr;
    logic [31:0]       set;
    logic [31:0]       busy_next;

    // A wins unless B also wants the port and, under round-robin, A won last time
    always_comb begin
        grant_a   = a_valid & (~b_valid | (FAIR == 1'b0) | last_b);
        grant_b   = b_valid & ~grant_a;
        a_ready   = grant_a;
        b_ready   = grant_b;
        sel_rd    = grant_a ? a_rd : b_rd;
        sel_data  = grant_a ? a_data : b_data;
        clr       = RegWrite ? (32'd1 << WriteRegister) : 32'd0;
        set       = (rsv_valid && rsv_rd != 5'd0) ? (32'd1 << rsv_rd) : 32'd0;
        // a fresh reservation outranks the commit clearing the same bit
        busy_next = (busy & ~clr) | set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b        <= 1'b1;
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= '0;
            busy          <= 32'd0;
        end else begin
            if (grant_a || grant_b) begin
                last_b        <= grant_b;
                WriteRegister <= sel_rd;
                WriteData     <= sel_data;
            end
            // x0 writes complete the handshake but never reach the regfile
            RegWrite <= (grant_a || grant_b) && sel_rd != 5'd0;
            busy     <= busy_next;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter (round-robin and fixed-priority builds).
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic        a_ready, b_ready, reg_write;
    logic [31:0] busy, write_data;
    logic [4:0]  write_register;
    logic        a_ready0, b_ready0, reg_write0;
    logic [31:0] busy0, write_data0;
    logic [4:0]  write_register0;
    int total;
    int bad;

    regfile_wb_arbiter #(.DATA_W(32), .FAIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .busy(busy),
        .RegWrite(reg_write), .WriteRegister(write_register), .WriteData(write_data)
    );

    regfile_wb_arbiter #(.DATA_W(32), .FAIR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready0), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready0), .b_rd(b_rd), .b_data(b_data),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .busy(busy0),
        .RegWrite(reg_write0), .WriteRegister(write_register0), .WriteData(write_data0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst_n = 1'b1;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        rsv_valid = 0; rsv_rd = 0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%0h exp=0", reg_write); end
        total++; if (write_register !== 5'd0) begin bad++; $display("FAIL reset_wreg got=%0h exp=0", write_register); end
        total++; if (write_data !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", write_data); end
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_contention;
        bit exp_a;
        a_valid = 1; a_rd = 5'd1; a_data = 32'h1111_1111;
        b_valid = 1; b_rd = 5'd2; b_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            total++; if (a_ready !== exp_a || b_ready !== !exp_a) begin bad++; $display("FAIL rr_grant%0d got a=%0b b=%0b exp a=%0b b=%0b", i, a_ready, b_ready, exp_a, !exp_a); end
            total++; if (a_ready0 !== 1'b1 || b_ready0 !== 1'b0) begin bad++; $display("FAIL fixed_grant%0d got a=%0b b=%0b exp a=1 b=0", i, a_ready0, b_ready0); end
            @(negedge clk);
            total++; if (reg_write !== 1'b1 || write_register !== (exp_a ? 5'd1 : 5'd2)) begin bad++; $display("FAIL rr_write%0d got we=%0b rd=%0d exp we=1 rd=%0d", i, reg_write, write_register, exp_a ? 1 : 2); end
            total++; if (write_register0 !== 5'd1 || write_data0 !== 32'h1111_1111) begin bad++; $display("FAIL fixed_write%0d got rd=%0d data=%0h exp rd=1 data=11111111", i, write_register0, write_data0); end
        end
        a_valid = 0; b_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL single_ready got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready); end
        @(negedge clk);
        a_valid = 0;
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL single_regwrite got=%0b exp=1", reg_write); end
        total++; if (write_register !== 5'd5) begin bad++; $display("FAIL single_wreg got=%0d exp=5", write_register); end
        total++; if (write_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wdata got=%0h exp=deadbeef", write_data); end
        @(negedge clk);
        total++; if (reg_write !== 1'b0 || write_register !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL idle_hold got we=%0b rd=%0d data=%0h exp we=0 rd=5 data=deadbeef", reg_write, write_register, write_data); end
    endtask

    task automatic test_x0;
        rsv_valid = 1; rsv_rd = 5'd3;
        @(negedge clk);
        rsv_valid = 1; rsv_rd = 5'd0;
        b_valid = 1; b_rd = 5'd0; b_data = 32'h0000_0123;
        #1;
        total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin bad++; $display("FAIL x0_ready got a=%0b b=%0b exp a=0 b=1", a_ready, b_ready); end
        @(negedge clk);
        b_valid = 0; rsv_valid = 0;
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL x0_regwrite got=%0b exp=0", reg_write); end
        total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL x0_busy got=%0h exp=8", busy); end
    endtask

    task automatic test_scoreboard;
        rsv_valid = 1; rsv_rd = 5'd7;
        @(negedge clk);
        rsv_valid = 0;
        total++; if (busy !== 32'h0000_0088) begin bad++; $display("FAIL sb_set got=%0h exp=88", busy); end
        a_valid = 1; a_rd = 5'd7; a_data = 32'h0000_0777;
        @(negedge clk);
        a_valid = 0;
        total++; if (reg_write !== 1'b1 || busy !== 32'h0000_0088) begin bad++; $display("FAIL sb_pending got we=%0b busy=%0h exp we=1 busy=88", reg_write, busy); end
        @(negedge clk);
        total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL sb_clear got=%0h exp=8", busy); end
        rsv_valid = 1; rsv_rd = 5'd7;
        @(negedge clk);
        rsv_valid = 0;
        a_valid = 1; a_rd = 5'd7; a_data = 32'h0000_0778;
        @(negedge clk);
        a_valid = 0;
        rsv_valid = 1; rsv_rd = 5'd7;
        @(negedge clk);
        rsv_valid = 0;
        total++; if (busy !== 32'h0000_0088) begin bad++; $display("FAIL sb_set_wins got=%0h exp=88", busy); end
    endtask

    task automatic test_same_rd;
        a_valid = 1; a_rd = 5'd9; a_data = 32'hAAAA_0001;
        b_valid = 1; b_rd = 5'd9; b_data = 32'hBBBB_0002;
        #1;
        total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin bad++; $display("FAIL same_rd_first got a=%0b b=%0b exp a=0 b=1", a_ready, b_ready); end
        @(negedge clk);
        b_valid = 0;
        total++; if (write_data !== 32'hBBBB_0002 || write_register !== 5'd9) begin bad++; $display("FAIL same_rd_b got rd=%0d data=%0h exp rd=9 data=bbbb0002", write_register, write_data); end
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL same_rd_second got a=%0b exp=1", a_ready); end
        @(negedge clk);
        a_valid = 0;
        total++; if (write_data !== 32'hAAAA_0001 || reg_write !== 1'b1) begin bad++; $display("FAIL same_rd_a got we=%0b data=%0h exp we=1 data=aaaa0001", reg_write, write_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        for (int r = 4; r < 7; r++) begin
            rsv_valid = 1; rsv_rd = r[4:0];
            @(negedge clk);
        end
        rsv_valid = 0;
        a_valid = 1; a_rd = 5'd3; a_data = 32'h0000_0333;
        @(negedge clk);
        a_rd = 5'd1; a_data = 32'h0000_0111;
        @(negedge clk);
        a_valid = 0;
        total++; if (reg_write !== 1'b1 || busy !== 32'h0000_00F0) begin bad++; $display("FAIL mid_pre got we=%0b busy=%0h exp we=1 busy=f0", reg_write, busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (reg_write !== 1'b0 || busy !== 32'd0 || write_register !== 5'd0 || write_data !== 32'd0) begin bad++; $display("FAIL mid_reset got we=%0b busy=%0h rd=%0d data=%0h exp all 0", reg_write, busy, write_register, write_data); end
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (reg_write !== 1'b0 || busy !== 32'd0) begin bad++; $display("FAIL mid_discard got we=%0b busy=%0h exp we=0 busy=0", reg_write, busy); end
        a_valid = 1; a_rd = 5'd2; b_valid = 1; b_rd = 5'd4;
        #1;
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL mid_first_grant got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready); end
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_contention();
        test_single();
        test_x0();
        test_scoreboard();
        test_same_rd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
